// File: rtl/conv_window_mac_pkg.sv
// Shared definitions for the convolution MAC slice: state encoding and
// width helpers reused by the pooling and fully-connected stages.
package conv_window_mac_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // One extra bit so an unsigned pixel times a signed weight always fits.
  function automatic int prod_w(input int dw, input int ww);
    return dw + ww + 1;
  endfunction

  function automatic int sum_w(input int dw, input int ww, input int n);
    return prod_w(dw, ww) + clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_mac_adder_tree.sv
// N-input signed sum with a single output register stage.
module adder_tree_reg #(
  parameter int N     = 9,
  parameter int IN_W  = 17,
  parameter int OUT_W = 21
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N-1:0][IN_W-1:0]  i_operands,
  output logic signed [OUT_W-1:0] o_sum
);

  logic signed [OUT_W-1:0] sum_c;

  // Operands are sign-extended to the full sum width before adding;
  // OUT_W is sized so the total cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int e = 0; e < N; e++)
      sum_c = sum_c + OUT_W'($signed(i_operands[e]));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sum <= '0;
    else          o_sum <= sum_c;
  end

endmodule

// File: rtl/conv_window_mac.sv
// Window x kernel multiply-accumulate with ReLU/saturation; suppresses
// windows that straddle a row boundary using a column counter.
module conv_window_mac import conv_window_mac_pkg::*; #(
  parameter int dataWidth    = 8,
  parameter int kernelWidth  = 3,
  parameter int kernelHeight = 3,
  parameter int imageWidth   = 256,
  parameter int weightWidth  = 8,
  parameter int outWidth     = 16,
  parameter int reluEn       = 1,
  parameter int firstCol     = 1
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic [kernelWidth*kernelHeight*dataWidth-1:0] i_window,
  input  logic                                        i_window_valid,
  input  logic                                        i_frame_start,
  input  logic                                        i_weight_load,
  input  logic [weightWidth-1:0]                      i_weight,
  input  logic                                        i_weight_valid,
  output logic                                        o_weights_ready,
  output logic [outWidth-1:0]                         o_data,
  output logic                                        o_data_valid
);

  localparam int N      = kernelWidth * kernelHeight;
  localparam int PW     = prod_w(dataWidth, weightWidth);
  localparam int SW     = sum_w(dataWidth, weightWidth, N);
  localparam int IW     = clog2(N + 1);
  localparam int CLW    = (imageWidth > 1) ? clog2(imageWidth) : 1;
  localparam int CW     = ((SW > outWidth) ? SW : outWidth) + 1;
  localparam int STAGES = 3;

  state_e                          state;
  logic [IW-1:0]                   idx;
  logic [N-1:0][weightWidth-1:0]   w_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      w_q             <= '0;
      o_weights_ready <= 1'b0;
    end else if (i_weight_load) begin
      state           <= ST_LOAD;
      o_weights_ready <= 1'b0;
      if (i_weight_valid) begin
        w_q[0] <= i_weight;
        idx    <= IW'(1);
      end else begin
        idx    <= '0;
      end
    end else if (state == ST_LOAD && i_weight_valid) begin
      for (int e = 0; e < N; e++)
        if (idx == IW'(e)) w_q[e] <= i_weight;
      idx <= idx + 1'b1;
      if (idx == IW'(N - 1)) begin
        state           <= ST_RUN;
        o_weights_ready <= 1'b1;
      end
    end
  end

  logic           acc;
  logic           s0_vld;
  logic [CLW-1:0] col, tag;

  assign acc    = i_window_valid && (state == ST_RUN);
  assign tag    = i_frame_start ? CLW'(firstCol) : col;
  // Until kernelWidth-1 columns of the new row have arrived the window
  // still contains pixels from the previous row.
  assign s0_vld = acc && (tag >= CLW'(kernelWidth - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           col <= CLW'(firstCol);
    else if (acc)           col <= (tag == CLW'(imageWidth - 1)) ? '0 : tag + 1'b1;
    else if (i_frame_start) col <= CLW'(firstCol);
  end

  logic [N-1:0][PW-1:0] prod_c, prod_q;
  logic [STAGES:1]      vld_pipe;

  always_comb begin
    for (int e = 0; e < N; e++)
      prod_c[e] = PW'($signed({1'b0, i_window[e*dataWidth +: dataWidth]}))
                * PW'($signed(w_q[e]));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_q   <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], s0_vld};
      if (acc) prod_q <= prod_c;
    end
  end

  logic signed [SW-1:0] sum_q;

  adder_tree_reg #(.N(N), .IN_W(PW), .OUT_W(SW)) u_tree (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_operands (prod_q),
    .o_sum      (sum_q)
  );

  logic signed [CW-1:0] ext, sat_max, sat_min, sat_c;

  always_comb begin
    sat_max = {{(CW-outWidth+1){1'b0}}, {(outWidth-1){1'b1}}};
    sat_min = ~sat_max;
    ext     = (reluEn != 0 && sum_q[SW-1]) ? '0 : CW'(sum_q);
    sat_c   = (ext > sat_max) ? sat_max : ((ext < sat_min) ? sat_min : ext);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            o_data <= '0;
    else if (vld_pipe[2])    o_data <= sat_c[outWidth-1:0];
  end

  assign o_data_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: three instances (ReLU on, ReLU off,
// 8-pixel rows) share one stimulus stream.
module tb_conv_window_mac;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [71:0] i_window;
  logic        wv, fs, wl, wvv;
  logic [7:0]  wt;

  logic        a_rdy, b_rdy, c_rdy, a_vld, b_vld, c_vld;
  logic [15:0] a_data, b_data, c_data;

  always #5 i_clk = ~i_clk;

  conv_window_mac dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_window(i_window), .i_window_valid(wv),
    .i_frame_start(fs), .i_weight_load(wl), .i_weight(wt), .i_weight_valid(wvv),
    .o_weights_ready(a_rdy), .o_data(a_data), .o_data_valid(a_vld));

  conv_window_mac #(.reluEn(0)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_window(i_window), .i_window_valid(wv),
    .i_frame_start(fs), .i_weight_load(wl), .i_weight(wt), .i_weight_valid(wvv),
    .o_weights_ready(b_rdy), .o_data(b_data), .o_data_valid(b_vld));

  conv_window_mac #(.imageWidth(8)) dut_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_window(i_window), .i_window_valid(wv),
    .i_frame_start(fs), .i_weight_load(wl), .i_weight(wt), .i_weight_valid(wvv),
    .o_weights_ready(c_rdy), .o_data(c_data), .o_data_valid(c_vld));

  int checks = 0, failures = 0;
  bit run;
  int col_ab, col_c;
  int cur_r, cur_n;
  bit ev_ab[3], ev_c[3];
  int ed_r[3], ed_n[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] b1(input logic v);
    return {31'b0, v};
  endfunction

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      ev_ab[i] = 0; ev_c[i] = 0; ed_r[i] = 0; ed_n[i] = 0;
    end
  endtask

  // One clock: work out which instances tag the window as geometrically
  // valid, then check the outputs for the window driven two edges earlier.
  task automatic cyc(input bit nrun);
    bit vab, vc;
    int tab, tc;
    vab = 0; vc = 0;
    if (wv && run) begin
      tab = fs ? 1 : col_ab;
      tc  = fs ? 1 : col_c;
      vab = (tab >= 2);
      vc  = (tc >= 2);
      col_ab = (tab + 1) % 256;
      col_c  = (tc + 1) % 8;
    end else if (fs) begin
      col_ab = 1; col_c = 1;
    end
    @(posedge i_clk);
    for (int i = 2; i > 0; i--) begin
      ev_ab[i] = ev_ab[i-1]; ev_c[i] = ev_c[i-1];
      ed_r[i]  = ed_r[i-1];  ed_n[i] = ed_n[i-1];
    end
    ev_ab[0] = vab; ev_c[0] = vc; ed_r[0] = cur_r; ed_n[0] = cur_n;
    run = nrun;
    @(negedge i_clk);
    chk("a_valid", b1(a_vld), b1(ev_ab[2]));
    chk("b_valid", b1(b_vld), b1(ev_ab[2]));
    chk("c_valid", b1(c_vld), b1(ev_c[2]));
    if (ev_ab[2]) begin
      chk("a_data", sx(a_data), ed_r[2]);
      chk("b_data", sx(b_data), ed_n[2]);
    end
    if (ev_c[2]) chk("c_data", sx(c_data), ed_r[2]);
    chk("a_ready", b1(a_rdy), b1(run));
    chk("c_ready", b1(c_rdy), b1(run));
  endtask

  task automatic load9(input logic [8:0][7:0] w);
    wl = 1; wvv = 1; wt = w[0];
    cyc(0);
    wl = 0;
    for (int i = 1; i < 9; i++) begin
      wt = w[i];
      cyc(i == 8);
    end
    wvv = 0;
  endtask

  task automatic set_win(input logic [7:0] pix);
    for (int e = 0; e < 9; e++) i_window[e*8 +: 8] = pix;
  endtask

  task automatic stream(input int n);
    wv = 1;
    for (int i = 0; i < n; i++) cyc(run);
    wv = 0;
  endtask

  task automatic drain();
    wv = 0;
    repeat (4) cyc(run);
  endtask

  initial begin
    i_rst_n = 0; wv = 0; fs = 0; wl = 0; wvv = 0; wt = '0; i_window = '0;
    run = 0; col_ab = 1; col_c = 1; cur_r = 0; cur_n = 0;
    clear_pipe();
    repeat (2) @(negedge i_clk);
    chk("rst_a_data", sx(a_data), 0);
    chk("rst_b_data", sx(b_data), 0);
    chk("rst_a_valid", b1(a_vld), 0);
    chk("rst_c_valid", b1(c_vld), 0);
    chk("rst_a_ready", b1(a_rdy), 0);
    chk("rst_b_ready", b1(b_rdy), 0);
    i_rst_n = 1;

    // Windows before any weights are loaded are dropped.
    set_win(8'd10); cur_r = 90; cur_n = 90;
    stream(3);

    load9({9{8'd1}});
    stream(5); drain();

    // Distinct weight per slot and pixel = slot index: sum e*(e+1) = 240.
    load9({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    for (int e = 0; e < 9; e++) i_window[e*8 +: 8] = 8'(e);
    cur_r = 240; cur_n = 240;
    stream(3); drain();

    load9({9{8'hFF}});
    set_win(8'd5); cur_r = 0; cur_n = -45;
    stream(3); drain();

    load9({9{8'd127}});
    set_win(8'd255); cur_r = 32767; cur_n = 32767;
    stream(2); drain();

    load9({9{8'h80}});
    cur_r = 0; cur_n = -32768;
    stream(2); drain();

    // Frame start with the first of 24 back-to-back windows.
    load9({9{8'd1}});
    set_win(8'd10); cur_r = 90; cur_n = 90;
    wv = 1; fs = 1; cyc(run); fs = 0;
    stream(23); drain();

    // Reload while streaming: in-flight windows keep the old weights.
    wv = 1;
    repeat (3) cyc(run);
    load9({9{8'd2}});
    cur_r = 180; cur_n = 180;
    stream(4); drain();

    // Reset with results in flight, then stream without reloading.
    wv = 1;
    repeat (3) cyc(run);
    i_rst_n = 0;
    #1;
    chk("async_rst_a_valid", b1(a_vld), 0);
    chk("async_rst_b_valid", b1(b_vld), 0);
    chk("async_rst_c_valid", b1(c_vld), 0);
    clear_pipe();
    run = 0; col_ab = 1; col_c = 1;
    cyc(0);
    i_rst_n = 1;
    stream(5); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
